// File: rtl/ifmd_window_fetch.sv
// ---------------------------------------------------------------------------
// ifmd_window_fetch
//
// Buffers the 8x8 byte input feature map written by the IFMD loader and, on
// request from the convolution engine, streams all 36 3x3 windows
// (stride 1, no padding) in raster order over a valid/ready handshake.
//
// Ports
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   IFMD_write  loader write strobe (accepted only while loading)
//   write_addr  pixel address, row*8+col
//   IFMD_in     pixel data
//   write_done  loader completion level; its rising edge ends the load
//   conv_start  request to begin streaming (honoured only in READY)
//   win_ready   consumer ready
//   win_valid   window valid
//   win_data    9 pixels, win_data[8k+:8] = pixel(r+k/3, c+k%3)
//   win_row     window origin row, 0..5
//   win_col     window origin column, 0..5
//   busy        high while READY or FETCH
//   fetch_done  one-cycle pulse after the final window handshake
// ---------------------------------------------------------------------------
module ifmd_window_fetch (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        IFMD_write,
    input  logic [5:0]  write_addr,
    input  logic [7:0]  IFMD_in,
    input  logic        write_done,
    input  logic        conv_start,
    input  logic        win_ready,
    output logic        win_valid,
    output logic [71:0] win_data,
    output logic [2:0]  win_row,
    output logic [2:0]  win_col,
    output logic        busy,
    output logic        fetch_done
);

    localparam int DATA_W  = 8;
    localparam int MAP_DIM = 8;
    localparam int K_DIM   = 3;
    localparam int WIN_W   = K_DIM * K_DIM * DATA_W;
    localparam logic [2:0] LAST_POS = 3'(MAP_DIM - K_DIM);

    typedef enum logic [1:0] {
        S_LOAD  = 2'd0,
        S_READY = 2'd1,
        S_FETCH = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                             r_state;
    state_t                             w_state_nxt;

    logic [MAP_DIM*MAP_DIM-1:0][DATA_W-1:0] r_mem;
    logic                               r_write_done_d;

    logic                               r_win_valid;
    logic [WIN_W-1:0]                   r_win_data;
    logic [2:0]                         r_win_row;
    logic [2:0]                         r_win_col;
    logic                               r_busy;
    logic                               r_fetch_done;

    logic                               w_load_evt;
    logic                               w_hs;
    logic                               w_last;
    logic [2:0]                         w_nxt_row;
    logic [2:0]                         w_nxt_col;
    logic [2:0]                         w_sel_row;
    logic [2:0]                         w_sel_col;
    logic [WIN_W-1:0]                   w_win;
    logic                               w_mem_we;

    // Gather the 3x3 window whose top-left pixel is (r, c). Addresses stay
    // within 0..63 because r, c never exceed 5.
    function automatic logic [WIN_W-1:0] f_window(
        input logic [MAP_DIM*MAP_DIM-1:0][DATA_W-1:0] mem,
        input logic [2:0] r,
        input logic [2:0] c
    );
        logic [WIN_W-1:0] win;
        logic [5:0]       addr;
        win = '0;
        for (int k = 0; k < K_DIM * K_DIM; k++) begin
            addr = 6'((int'(r) + k / K_DIM) * MAP_DIM + int'(c) + k % K_DIM);
            win[DATA_W*k +: DATA_W] = mem[addr];
        end
        return win;
    endfunction

    // ------------------------------------------------------------------
    // Control decode
    // ------------------------------------------------------------------
    assign w_load_evt = write_done & ~r_write_done_d;
    assign w_hs       = r_win_valid & win_ready;
    assign w_last     = (r_win_row == LAST_POS) && (r_win_col == LAST_POS);
    assign w_mem_we   = (r_state == S_LOAD) && IFMD_write;

    // Raster advance: column first, row steps when the column wraps.
    assign w_nxt_col  = (r_win_col == LAST_POS) ? 3'd0 : 3'(r_win_col + 3'd1);
    assign w_nxt_row  = (r_win_col == LAST_POS) ? 3'(r_win_row + 3'd1) : r_win_row;

    // One shared window gather: origin (0,0) when launching from READY,
    // otherwise the next raster position during FETCH.
    always_comb begin
        w_sel_row = w_nxt_row;
        w_sel_col = w_nxt_col;
        if (r_state == S_READY) begin
            w_sel_row = 3'd0;
            w_sel_col = 3'd0;
        end
    end

    assign w_win = f_window(r_mem, w_sel_row, w_sel_col);

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_LOAD: begin
                if (w_load_evt) begin
                    w_state_nxt = S_READY;
                end
            end
            S_READY: begin
                if (conv_start) begin
                    w_state_nxt = S_FETCH;
                end
            end
            S_FETCH: begin
                if (w_hs && w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_LOAD;
            end
            default: begin
                w_state_nxt = S_LOAD;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State and edge-detect registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= S_LOAD;
            r_write_done_d <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_write_done_d <= write_done;
        end
    end

    // ------------------------------------------------------------------
    // Pixel buffer: written only while loading; contents survive a pass so
    // a later load can patch individual bytes.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem <= '0;
        end else if (w_mem_we) begin
            r_mem[write_addr] <= IFMD_in;
        end
    end

    // ------------------------------------------------------------------
    // Output registers. busy and fetch_done are decoded from the next
    // state so they line up with the state they describe.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_win_valid  <= 1'b0;
            r_win_data   <= '0;
            r_win_row    <= 3'd0;
            r_win_col    <= 3'd0;
            r_busy       <= 1'b0;
            r_fetch_done <= 1'b0;
        end else begin
            r_busy       <= (w_state_nxt == S_READY) || (w_state_nxt == S_FETCH);
            r_fetch_done <= (w_state_nxt == S_DONE);
            unique case (r_state)
                S_READY: begin
                    if (conv_start) begin
                        r_win_valid <= 1'b1;
                        r_win_row   <= 3'd0;
                        r_win_col   <= 3'd0;
                        r_win_data  <= w_win;
                    end
                end
                S_FETCH: begin
                    if (w_hs) begin
                        if (w_last) begin
                            // Final window accepted; hold its coordinates.
                            r_win_valid <= 1'b0;
                        end else begin
                            r_win_valid <= 1'b1;
                            r_win_row   <= w_nxt_row;
                            r_win_col   <= w_nxt_col;
                            r_win_data  <= w_win;
                        end
                    end
                end
                default: begin
                    r_win_valid <= 1'b0;
                end
            endcase
        end
    end

    assign win_valid  = r_win_valid;
    assign win_data   = r_win_data;
    assign win_row    = r_win_row;
    assign win_col    = r_win_col;
    assign busy       = r_busy;
    assign fetch_done = r_fetch_done;

endmodule

// File: tb/tb_ifmd_window_fetch.sv
// ---------------------------------------------------------------------------
// tb_ifmd_window_fetch
//
// Directed bench for ifmd_window_fetch. Inputs change and outputs are
// sampled on the falling clock edge, half a cycle away from the active edge.
// ---------------------------------------------------------------------------
module tb_ifmd_window_fetch;

    logic        clk;
    logic        rst_n;
    logic        IFMD_write;
    logic [5:0]  write_addr;
    logic [7:0]  IFMD_in;
    logic        write_done;
    logic        conv_start;
    logic        win_ready;
    logic        win_valid;
    logic [71:0] win_data;
    logic [2:0]  win_row;
    logic [2:0]  win_col;
    logic        busy;
    logic        fetch_done;

    int n_pass;
    int n_total;

    logic [7:0]  tb_mem [64];
    logic [71:0] win00;
    logic [71:0] win05;
    logic [71:0] win55;
    logic [71:0] win11;
    logic [71:0] win_all11;
    logic [71:0] held_data;

    ifmd_window_fetch dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .IFMD_write (IFMD_write),
        .write_addr (write_addr),
        .IFMD_in    (IFMD_in),
        .write_done (write_done),
        .conv_start (conv_start),
        .win_ready  (win_ready),
        .win_valid  (win_valid),
        .win_data   (win_data),
        .win_row    (win_row),
        .win_col    (win_col),
        .busy       (busy),
        .fetch_done (fetch_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [71:0] exp_win(input int r, input int c);
        logic [71:0] w;
        w = '0;
        for (int k = 0; k < 9; k++) begin
            w[8*k +: 8] = tb_mem[(r + k / 3) * 8 + c + k % 3];
        end
        return w;
    endfunction

    task automatic chk_window(input string tag, input int i, input logic [71:0] exp_data);
        chk({tag, "_valid"}, 72'(win_valid), 72'd1);
        chk({tag, "_row"},   72'(win_row),   72'(i / 6));
        chk({tag, "_col"},   72'(win_col),   72'(i % 6));
        chk({tag, "_data"},  win_data,       exp_data);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"}, 72'(win_valid),  72'd0);
        chk({tag, "_data"},  win_data,        72'd0);
        chk({tag, "_row"},   72'(win_row),    72'd0);
        chk({tag, "_col"},   72'(win_col),    72'd0);
        chk({tag, "_busy"},  72'(busy),       72'd0);
        chk({tag, "_fdone"}, 72'(fetch_done), 72'd0);
    endtask

    initial begin
        n_pass     = 0;
        n_total    = 0;
        rst_n      = 1'b0;
        IFMD_write = 1'b0;
        write_addr = '0;
        IFMD_in    = '0;
        write_done = 1'b0;
        conv_start = 1'b0;
        win_ready  = 1'b1;
        win00      = {8'd18, 8'd17, 8'd16, 8'd10, 8'd9,  8'd8,  8'd2,  8'd1,  8'd0};
        win05      = {8'd23, 8'd22, 8'd21, 8'd15, 8'd14, 8'd13, 8'd7,  8'd6,  8'd5};
        win55      = {8'd63, 8'd62, 8'd61, 8'd55, 8'd54, 8'd53, 8'd47, 8'd46, 8'd45};
        win11      = {8'd27, 8'd26, 8'd25, 8'd19, 8'd18, 8'd17, 8'd11, 8'd10, 8'd9};
        win_all11  = {9{8'h11}};
        for (int a = 0; a < 64; a++) tb_mem[a] = 8'(a);

        // Reset values
        step();
        step();
        chk_all_zero("reset");
        rst_n = 1'b1;

        // conv_start in LOAD is ignored
        conv_start = 1'b1;
        for (int n = 0; n < 3; n++) begin
            step();
            chk("load_cs_valid", 72'(win_valid), 72'd0);
            chk("load_cs_busy",  72'(busy),      72'd0);
        end
        conv_start = 1'b0;

        // Ramp load; the final write shares its cycle with the write_done edge
        for (int a = 0; a < 64; a++) begin
            IFMD_write = 1'b1;
            write_addr = 6'(a);
            IFMD_in    = 8'(a);
            write_done = (a == 63);
            step();
        end
        IFMD_write = 1'b0;
        chk("ready_busy",  72'(busy),      72'd1);
        chk("ready_valid", 72'(win_valid), 72'd0);

        // Pass 1: win_ready held high, a stray write during FETCH
        conv_start = 1'b1;
        step();
        conv_start = 1'b0;
        IFMD_write = 1'b1;
        write_addr = 6'd0;
        IFMD_in    = 8'hFF;
        for (int i = 0; i < 36; i++) begin
            chk_window("p1", i, exp_win(i / 6, i % 6));
            chk("p1_busy", 72'(busy), 72'd1);
            if (i == 0)  chk("p1_win00", win_data, win00);
            if (i == 5)  chk("p1_win05", win_data, win05);
            if (i == 35) chk("p1_win55", win_data, win55);
            step();
            IFMD_write = 1'b0;
        end
        chk("p1_fdone",       72'(fetch_done), 72'd1);
        chk("p1_end_valid",   72'(win_valid),  72'd0);
        chk("p1_end_busy",    72'(busy),       72'd0);
        step();
        chk("p1_fdone_pulse", 72'(fetch_done), 72'd0);

        // write_done still high: no retrigger, conv_start ignored in LOAD
        conv_start = 1'b1;
        for (int n = 0; n < 4; n++) begin
            step();
            chk("wd_level_busy",  72'(busy),      72'd0);
            chk("wd_level_valid", 72'(win_valid), 72'd0);
        end
        conv_start = 1'b0;
        write_done = 1'b0;
        step();
        chk("wd_low_busy", 72'(busy), 72'd0);
        write_done = 1'b1;
        step();
        chk("wd_rise_busy", 72'(busy), 72'd1);

        // Pass 2: backpressure on window (1,1); buffer retained from pass 1
        conv_start = 1'b1;
        step();
        conv_start = 1'b0;
        for (int i = 0; i < 36; i++) begin
            chk_window("p2", i, exp_win(i / 6, i % 6));
            if (i == 0) chk("p2_no_ff", win_data, win00);
            if (i == 7) begin
                chk("p2_win11", win_data, win11);
                held_data = win_data;
                win_ready = 1'b0;
                for (int n = 0; n < 3; n++) begin
                    step();
                    chk("bp_valid", 72'(win_valid), 72'd1);
                    chk("bp_row",   72'(win_row),   72'd1);
                    chk("bp_col",   72'(win_col),   72'd1);
                    chk("bp_data",  win_data,       win11);
                    chk("bp_hold",  win_data,       held_data);
                end
                win_ready = 1'b1;
            end
            step();
        end
        chk("p2_fdone",     72'(fetch_done), 72'd1);
        chk("p2_end_valid", 72'(win_valid),  72'd0);

        // Pass 3: async reset at window (3,2)
        write_done = 1'b0;
        step();
        write_done = 1'b1;
        step();
        chk("p3_busy", 72'(busy), 72'd1);
        conv_start = 1'b1;
        step();
        conv_start = 1'b0;
        for (int i = 0; i <= 20; i++) begin
            chk_window("p3", i, exp_win(i / 6, i % 6));
            if (i < 20) step();
        end
        rst_n      = 1'b0;
        write_done = 1'b0;
        #1;
        chk_all_zero("async_rst");
        step();
        step();
        rst_n = 1'b1;

        // Reload 0x11 everywhere, address 0 written just before write_done rises
        for (int a = 63; a >= 0; a--) begin
            IFMD_write = 1'b1;
            write_addr = 6'(a);
            IFMD_in    = 8'h11;
            step();
        end
        IFMD_write = 1'b0;
        write_done = 1'b1;
        step();
        chk("p4_busy", 72'(busy), 72'd1);
        conv_start = 1'b1;
        step();
        conv_start = 1'b0;
        for (int i = 0; i < 36; i++) begin
            chk_window("p4", i, win_all11);
            step();
        end
        chk("p4_fdone",     72'(fetch_done), 72'd1);
        chk("p4_end_valid", 72'(win_valid),  72'd0);
        step();
        chk("p4_fdone_pulse", 72'(fetch_done), 72'd0);
        chk("p4_end_busy",    72'(busy),       72'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
